// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC parameters, FSM state type and elaboration-time constant builders
package cordic_pkg;

    localparam int WIDTH_DEF = 24;
    localparam int ITER_DEF  = 16;
    localparam int GUARD     = 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Fixed-point scale used while building constants; far finer than any table entry.
    localparam int CSCALE = 56;

    // atan(1/m) at 2^CSCALE via the alternating Taylor series, exact integer arithmetic.
    function automatic longint atan_recip(input longint m);
        longint p;
        longint m2;
        longint sum;
        p   = (longint'(1) <<< CSCALE) / m;
        m2  = m * m;
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            if (p != 0) begin
                if (k % 2 == 0)
                    sum = sum + p / longint'(2 * k + 1);
                else
                    sum = sum - p / longint'(2 * k + 1);
                p = p / m2;
            end
        end
        return sum;
    endfunction

    // round(atan(2^-i) * 2^(width+GUARD)); atan(1) is built as atan(1/2) + atan(1/3).
    function automatic longint atan_entry(input int i, input int width);
        longint v;
        int     frac;
        frac = width + GUARD;
        if (i == 0)
            v = atan_recip(2) + atan_recip(3);
        else
            v = atan_recip(longint'(1) <<< i);
        return (v + (longint'(1) <<< (CSCALE - frac - 1))) >>> (CSCALE - frac);
    endfunction

    // prod 1/sqrt(1+2^-2i) at 2^(width+GUARD): square accumulated at 2^62, then integer sqrt.
    function automatic longint gain_k(input int width, input int iter);
        longint k2;
        longint r;
        longint t;
        int     frac;
        frac = width + GUARD;
        k2   = longint'(1) <<< 62;
        for (int i = 0; i < iter; i++)
            k2 = k2 - k2 / ((longint'(1) <<< (2 * i)) + 1);
        r = 0;
        for (int b = 30; b >= 0; b--) begin
            t = r | (longint'(1) <<< b);
            if (t * t <= k2)
                r = t;
        end
        return (r + (longint'(1) <<< (30 - frac))) >>> (31 - frac);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational arctangent table, one entry per micro-rotation
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF,
    localparam int IW   = WIDTH + 2 + GUARD,
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1
) (
    input  logic [CW-1:0]        idx,
    output logic signed [IW-1:0] atan
);

    logic signed [IW-1:0] rom [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_rom
        localparam longint ENTRY = atan_entry(g, WIDTH);
        assign rom[g] = ENTRY[IW-1:0];
    end

    always_comb begin
        atan = '0;
        if (32'(idx) < ITER)
            atan = rom[idx];
    end

endmodule

// File: rtl/cordic_cos_iter.sv
// rtl/cordic_cos_iter.sv - iterative rotation-mode CORDIC, one micro-rotation per enabled clock
module cordic_cos_iter
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    start,
    input  logic signed [WIDTH+1:0] theta,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH+1:0] cos_out,
    output logic signed [WIDTH+1:0] sin_out
);

    localparam int DW = WIDTH + 2;
    localparam int IW = DW + GUARD;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic signed [IW-1:0] K_INIT = IW'(gain_k(WIDTH, ITER));

    state_t               state;
    logic [CW-1:0]        i;
    logic signed [IW-1:0] x;
    logic signed [IW-1:0] y;
    logic signed [IW-1:0] z;
    logic signed [IW-1:0] xs;
    logic signed [IW-1:0] ys;
    logic signed [IW-1:0] atan_i;
    logic                 d;

    assign xs = x >>> i;
    assign ys = y >>> i;
    assign d  = ~z[IW-1];

    cordic_atan_rom #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_rom (
        .idx  (i),
        .atan (atan_i)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            i       <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= K_INIT;
                        y     <= '0;
                        z     <= {theta, {GUARD{1'b0}}};
                        i     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    x <= d ? (x - ys) : (x + ys);
                    y <= d ? (y + xs) : (y - xs);
                    z <= d ? (z - atan_i) : (z + atan_i);
                    i <= i + 1'b1;
                    if (i == CW'(ITER - 1))
                        state <= DONE;
                end
                DONE: begin
                    // Truncating the guard bits is the arithmetic right shift by GUARD.
                    cos_out <= x[IW-1 -: DW];
                    sin_out <= y[IW-1 -: DW];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_cos_iter.sv
// tb/tb_cordic_cos_iter.sv - self-checking bench for cordic_cos_iter against ideal cos/sin
module tb_cordic_cos_iter;

    localparam int  WIDTH = 24;
    localparam int  ITER  = 16;
    localparam int  DW    = WIDTH + 2;
    localparam int  TOL   = 1024;
    localparam int  LAT   = ITER + 2;
    localparam real ONE   = 16777216.0;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          start;
    logic [DW-1:0] theta;
    logic          busy;
    logic          done;
    logic [DW-1:0] cos_out;
    logic [DW-1:0] sin_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cordic_cos_iter #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .start   (start),
        .theta   (theta),
        .busy    (busy),
        .done    (done),
        .cos_out (cos_out),
        .sin_out (sin_out)
    );

    typedef struct {
        logic [DW-1:0] th;
        logic [DW-1:0] c;
        logic [DW-1:0] s;
    } vec_t;

    vec_t vecs [5];

    task automatic check_near(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        int g;
        int e;
        int diff;
        g    = $signed(got);
        e    = $signed(exp);
        diff = g - e;
        n_vec++;
        if (diff > TOL || diff < -TOL) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h +/-%0d", name, got, exp, TOL);
        end
    endtask

    task automatic check_eq(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    function automatic void ideal(input logic [DW-1:0] th, output logic [DW-1:0] c, output logic [DW-1:0] s);
        int  ti;
        real a;
        ti = $signed(th);
        a  = $itor(ti) / ONE;
        c  = DW'($rtoi($floor($cos(a) * ONE + 0.5)));
        s  = DW'($rtoi($floor($sin(a) * ONE + 0.5)));
    endfunction

    function automatic logic [DW-1:0] rand_theta();
        int ti;
        ti = int'($urandom_range(0, 33554432)) - 16777216;
        return DW'(ti);
    endfunction

    // Caller is at a negedge. Returns at the negedge where done is first seen high.
    task automatic run_op(input logic [DW-1:0] th, input bit rnd_en, input bit hold, input int pulse_at,
                          output logic [DW-1:0] c, output logic [DW-1:0] s, output int edges);
        int cyc;
        theta  = th;
        start  = 1'b1;
        clk_en = 1'b1;
        edges  = 0;
        cyc    = 0;
        while (1) begin
            @(posedge clk);
            if (clk_en) edges++;
            @(negedge clk);
            if (done) break;
            cyc++;
            if (cyc > 300) begin
                n_vec++;
                n_bad++;
                $display("FAIL op_timeout: no done after %0d cycles, theta %h", cyc, th);
                break;
            end
            if (!hold) begin
                start = (pulse_at != 0 && cyc == pulse_at);
                theta = rand_theta();
            end
            clk_en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        c      = cos_out;
        s      = sin_out;
        clk_en = 1'b1;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] c;
        logic [DW-1:0] s;
        logic [DW-1:0] ec;
        logic [DW-1:0] es;
        logic [DW-1:0] c1;
        logic [DW-1:0] th;
        int            e;
        int            edges2;
        int            unstable;
        int            extra;

        vecs[0] = '{26'h0000000, 26'h1000000, 26'h0000000};
        vecs[1] = '{26'h1000000, 26'h08A5140, 26'h0D76AA4};
        vecs[2] = '{26'h3000000, 26'h08A5140, 26'h328955C};
        vecs[3] = '{26'h0800000, 26'h0E0A941, 26'h07ABB98};
        vecs[4] = '{26'h3800000, 26'h0E0A941, 26'h3854468};

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        theta  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_cos", cos_out, 0);
        check_eq("reset_sin", sin_out, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            run_op(vecs[k].th, 1'b0, 1'b0, 0, c, s, e);
            check_near($sformatf("table_cos[%0d]", k), c, vecs[k].c);
            check_near($sformatf("table_sin[%0d]", k), s, vecs[k].s);
            check_eq($sformatf("table_latency[%0d]", k), e, LAT);
        end

        for (int k = 0; k < 12; k++) begin
            th = rand_theta();
            ideal(th, ec, es);
            run_op(th, 1'b1, 1'b0, 0, c, s, e);
            check_near($sformatf("rand_cos[%0d]", k), c, ec);
            check_near($sformatf("rand_sin[%0d]", k), s, es);
            check_eq($sformatf("rand_en_edges[%0d]", k), e, LAT);
        end

        // start held through completion: second op is accepted on the return to IDLE
        run_op(26'h0800000, 1'b0, 1'b1, 0, c1, s, e);
        check_near("hold_first_cos", c1, 26'h0E0A941);
        check_eq("hold_first_latency", e, LAT);
        theta = 26'h3800000;
        @(posedge clk);
        edges2 = 1;
        @(negedge clk);
        start = 1'b0;
        theta = rand_theta();
        check_eq("hold_second_busy", busy, 1);
        check_eq("hold_second_done_low", done, 0);
        unstable = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            edges2++;
            @(negedge clk);
            if (done) break;
            if (cos_out != c1) unstable++;
        end
        check_eq("hold_outputs_stable", unstable, 0);
        check_eq("hold_second_latency", edges2, LAT);
        check_near("hold_second_cos", cos_out, 26'h0E0A941);
        check_near("hold_second_sin", sin_out, 26'h3854468);

        // reset while the rotation loop is at i=7, with clk_en low
        theta = 26'h1000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        clk_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrun_reset_busy", busy, 0);
        check_eq("midrun_reset_done", done, 0);
        check_eq("midrun_reset_cos", cos_out, 0);
        check_eq("midrun_reset_sin", sin_out, 0);
        reset = 1'b0;
        ideal(26'h0C00000, ec, es);
        run_op(26'h0C00000, 1'b0, 1'b0, 0, c, s, e);
        check_near("post_reset_cos", c, ec);
        check_near("post_reset_sin", s, es);
        check_eq("post_reset_latency", e, LAT);

        // stray start in the middle of an operation
        th = 26'h3400000;
        ideal(th, ec, es);
        run_op(th, 1'b0, 1'b0, 5, c, s, e);
        check_near("pulse_cos", c, ec);
        check_near("pulse_sin", s, es);
        check_eq("pulse_latency", e, LAT);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check_eq("pulse_single_done", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
